// File: rtl/audio_pkg.sv
// Shared constants and types for the tone phase generator and its PWM renderer.
package audio_pkg;

    localparam int DEFAULT_BITS  = 6;
    localparam int DEFAULT_ACC_W = 16;

    localparam logic [4:0] SILENT_ID = 5'd31;
    localparam logic [4:0] NOTE_A2   = 5'd0;
    localparam logic [4:0] NOTE_A4   = 5'd24;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } note_state_t;

endpackage

// File: rtl/pwm_dac.sv
// Renders a signed sample as a 1-bit PWM stream using a free-running counter.
module pwm_dac #(
    parameter int BITS = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic signed [BITS:0] sample,
    output logic                pwm_out
);

    logic [BITS:0]   r_pc;
    logic            r_pwm;
    logic [BITS+1:0] w_level;

    // Offset binary: sample + 2^BITS, always in 1..2^(BITS+1)-1
    assign w_level = {sample[BITS], sample} + {2'b01, {BITS{1'b0}}};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pc  <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_pc  <= r_pc + (BITS+1)'(1);
            r_pwm <= ({1'b0, r_pc} < w_level);
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: rtl/tone_phase_gen.sv
// Phase-accumulator tone generator: note handoff at zero crossings, signed
// sample reconstruction from an external |sin| ROM, PWM output.
//
// state      | meaning
// ST_IDLE    | no note pending, note_ready high
// ST_PENDING | note captured, waiting for a wrapping tick or silent active id
module tone_phase_gen
    import audio_pkg::*;
#(
    parameter int BITS  = DEFAULT_BITS,
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic [4:0]           note_id,
    input  logic                 note_valid,
    output logic                 note_ready,
    output logic [10:0]          rom_index,
    output logic [4:0]           rom_freq_id,
    input  logic [BITS-1:0]      rom_level,
    input  logic [15:0]          rom_freq,
    output logic signed [BITS:0] sample,
    output logic                 sample_valid,
    output logic                 pwm_out
);

    note_state_t r_state;
    note_state_t w_state_nxt;

    logic [ACC_W-1:0]     r_acc;
    logic [4:0]           r_active_id;
    logic [4:0]           r_pending_id;
    logic                 r_tick_d;
    logic signed [BITS:0] r_sample;
    logic                 r_sample_valid;

    logic [ACC_W:0]       w_sum;
    logic                 w_wrap;
    logic                 w_accept;
    logic                 w_apply;
    logic signed [BITS:0] w_mag;
    logic signed [BITS:0] w_signed;

    assign w_sum    = {1'b0, r_acc} + (ACC_W+1)'(rom_freq);
    assign w_wrap   = sample_tick & w_sum[ACC_W];
    assign w_accept = note_valid & (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (note_valid) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_wrap || (r_active_id == SILENT_ID)) begin
                    w_apply     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pending_id <= SILENT_ID;
            r_active_id  <= SILENT_ID;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_pending_id <= note_id;
            end
            if (w_apply) begin
                r_active_id <= r_pending_id;
            end
        end
    end

    // The wrapped remainder is kept across a note change to stay phase-continuous
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc    <= '0;
            r_tick_d <= 1'b0;
        end else begin
            r_tick_d <= sample_tick;
            if (sample_tick) begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign rom_index   = {1'b0, r_acc[ACC_W-1 -: 10]};
    assign rom_freq_id = r_active_id;
    assign note_ready  = (r_state == ST_IDLE);

    // Second half of the cycle is the negative lobe
    assign w_mag    = {1'b0, rom_level};
    assign w_signed = rom_index[9] ? -w_mag : w_mag;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= r_tick_d;
            if (r_tick_d) begin
                r_sample <= w_signed;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;

    pwm_dac #(
        .BITS (BITS)
    ) u_pwm_dac (
        .clock   (clock),
        .reset_n (reset_n),
        .sample  (r_sample),
        .pwm_out (pwm_out)
    );

endmodule
